// File: rtl/frame_capture_writer.sv
// Captures one camera frame per write window, packing byte pairs into
// RGB565 words and writing them sequentially into the frame buffer RAM.
module frame_capture_writer #(
  parameter int ADDR_W      = 17,
  parameter int FRAME_WORDS = 76800,
  parameter int LINE_WORDS  = 320
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              select,
  input  logic              internal_vsync,
  input  logic              href,
  input  logic              pixel_valid,
  input  logic [7:0]        pixel_byte,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic              abort,
  output logic [ADDR_W-1:0] word_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [ADDR_W-1:0] L_FRAME = ADDR_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] L_LINE  = ADDR_W'(LINE_WORDS);
  localparam logic [ADDR_W-1:0] L_ONE   = ADDR_W'(1);

  logic [1:0]        r_state;
  logic              r_phase;
  logic [7:0]        r_hi;
  logic [ADDR_W-1:0] r_line_cnt;
  logic              r_href_d;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [15:0]       r_wr_data;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_frame_err;
  logic              r_abort;
  logic [ADDR_W-1:0] r_word_count;

  logic [1:0]        w_next;
  logic              w_capturing;
  logic              w_accept;
  logic              w_href_fall;
  logic              w_full;
  logic              w_start;
  logic              w_end;

  // Next-state logic; entering WAIT with vsync high makes its first low cycle the frame start.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (select && internal_vsync) w_next = S_WAIT;
        else                          w_next = S_IDLE;
      end
      S_WAIT: begin
        if (!select)              w_next = S_IDLE;
        else if (!internal_vsync) w_next = S_CAPTURE;
        else                      w_next = S_WAIT;
      end
      S_CAPTURE: begin
        if (!select)             w_next = S_IDLE;
        else if (internal_vsync) w_next = S_DONE;
        else                     w_next = S_CAPTURE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Bytes arriving in an exit cycle are not part of the frame.
  assign w_capturing = (r_state == S_CAPTURE) && (w_next == S_CAPTURE);
  assign w_accept    = w_capturing && pixel_valid && href;
  assign w_href_fall = w_capturing && r_href_d && !href;
  assign w_full      = (r_word_count == L_FRAME);
  assign w_start     = (r_state == S_WAIT) && (w_next == S_CAPTURE);
  assign w_end       = (r_state == S_CAPTURE) && (w_next == S_DONE);

  // Sequencing, packing, line/frame checks and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_phase      <= 1'b0;
      r_hi         <= 8'd0;
      r_line_cnt   <= '0;
      r_href_d     <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= 16'd0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_abort      <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_state      <= w_next;
      r_href_d     <= href;
      r_busy       <= (w_next == S_WAIT) || (w_next == S_CAPTURE);
      r_frame_done <= w_end;
      r_abort      <= (r_state == S_CAPTURE) && (w_next == S_IDLE);
      r_wr_en      <= 1'b0;
      // Address advances after each write but parks on the last word of a full frame.
      if (r_wr_en && !w_full) begin
        r_wr_addr <= r_wr_addr + L_ONE;
      end
      if (w_start) begin
        r_wr_addr    <= '0;
        r_word_count <= '0;
        r_frame_err  <= 1'b0;
        r_phase      <= 1'b0;
        r_line_cnt   <= '0;
      end else if (w_accept) begin
        if (!r_phase) begin
          r_hi    <= pixel_byte;
          r_phase <= 1'b1;
        end else begin
          r_phase    <= 1'b0;
          r_line_cnt <= r_line_cnt + L_ONE;
          if (w_full) begin
            r_frame_err <= 1'b1;
          end else begin
            r_wr_en      <= 1'b1;
            r_wr_data    <= {r_hi, pixel_byte};
            r_word_count <= r_word_count + L_ONE;
          end
        end
      end else if (w_href_fall) begin
        if ((r_line_cnt != L_LINE) || r_phase) begin
          r_frame_err <= 1'b1;
        end
        r_phase    <= 1'b0;
        r_line_cnt <= '0;
      end else if (w_end) begin
        if (!w_full) begin
          r_frame_err <= 1'b1;
        end
      end
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign abort      = r_abort;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_frame_capture_writer.sv
// Randomised directed bench for frame_capture_writer against a line-level frame model.
module tb_frame_capture_writer;
  localparam int AW = 8;
  localparam int FW = 16;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          select = 1'b0;
  logic          internal_vsync = 1'b0;
  logic          href = 1'b0;
  logic          pixel_valid = 1'b0;
  logic [7:0]    pixel_byte = 8'd0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          busy;
  logic          frame_done;
  logic          frame_err;
  logic          abort;
  logic [AW-1:0] word_count;

  frame_capture_writer #(.ADDR_W(AW), .FRAME_WORDS(FW), .LINE_WORDS(LW)) dut (
    .clk(clk), .reset(reset), .select(select), .internal_vsync(internal_vsync),
    .href(href), .pixel_valid(pixel_valid), .pixel_byte(pixel_byte),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err), .abort(abort),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Observed bus activity, sampled mid-cycle.
  logic [AW+15:0] got_q[$];
  int   done_cnt;
  int   abort_cnt;
  logic err_at_done;

  always @(negedge clk) begin
    if (wr_en) got_q.push_back({wr_addr, wr_data});
    if (frame_done) begin
      done_cnt    = done_cnt + 1;
      err_at_done = frame_err;
    end
    if (abort) abort_cnt = abort_cnt + 1;
  end

  // Reference model: per-line byte counts turned into words and an error verdict.
  logic [15:0] exp_q[$];
  int   m_total;
  bit   m_err;
  int   seq_val;
  int   lens[8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_obs();
    got_q.delete();
    exp_q.delete();
    done_cnt = 0;
    abort_cnt = 0;
    err_at_done = 1'bx;
    m_total = 0;
    m_err = 1'b0;
  endtask

  task automatic send_line(input int n, input bit seq, input bit model);
    logic [7:0] b;
    logic [7:0] first;
    first = 8'd0;
    href = 1'b1;
    tick(1);
    for (int i = 0; i < n; i++) begin
      if (seq) begin
        b = seq_val[7:0];
        seq_val++;
      end else begin
        b = 8'($urandom_range(0, 255));
      end
      pixel_valid = 1'b1;
      pixel_byte = b;
      tick(1);
      pixel_valid = 1'b0;
      tick($urandom_range(0, 1));
      if (model) begin
        if (i % 2 == 0) begin
          first = b;
        end else begin
          if (m_total < FW) exp_q.push_back({first, b});
          m_total++;
        end
      end
    end
    href = 1'b0;
    tick(2);
    if (model && ((n % 2) != 0 || (n / 2) != LW)) m_err = 1'b1;
  endtask

  task automatic frame_open();
    select = 1'b1;
    internal_vsync = 1'b1;
    tick(5);
    internal_vsync = 1'b0;
    tick(3);
  endtask

  task automatic run_frame(input int nl, input bit seq);
    clear_obs();
    seq_val = 0;
    frame_open();
    for (int l = 0; l < nl; l++) send_line(lens[l], seq, 1'b1);
    internal_vsync = 1'b1;
    tick(5);
    if (m_total != FW) m_err = 1'b1;
  endtask

  task automatic check_writes(input string tag);
    int n;
    chk({tag, ".nwr"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, ".addr"}, 32'(got_q[i][AW+15:16]), i);
      chk({tag, ".data"}, 32'(got_q[i][15:0]), 32'(exp_q[i]));
    end
  endtask

  task automatic check_frame(input string tag);
    check_writes(tag);
    chk({tag, ".done"}, done_cnt, 1);
    chk({tag, ".abort"}, abort_cnt, 0);
    chk({tag, ".err"}, 32'(err_at_done), 32'(m_err));
    chk({tag, ".wc"}, 32'(word_count), (m_total < FW) ? m_total : FW);
  endtask

  initial begin
    clear_obs();
    tick(3);
    chk("reset.outs", {wr_en, wr_addr, wr_data, busy, frame_done, frame_err, abort, word_count}, 32'd0);
    reset = 1'b0;
    tick(2);

    // Nominal frame with sequential bytes
    for (int l = 0; l < 4; l++) lens[l] = 8;
    run_frame(4, 1'b1);
    check_frame("nominal");
    chk("nominal.first", 32'(exp_q[0]), 32'h0001);
    chk("nominal.last", 32'(got_q[FW-1][15:0]), 32'h1E1F);

    // Odd-length second line
    lens[1] = 7;
    run_frame(4, 1'b0);
    check_frame("oddline");

    // Overflow with five full lines
    for (int l = 0; l < 5; l++) lens[l] = 8;
    run_frame(5, 1'b0);
    check_frame("overflow");
    chk("overflow.addr_hold", 32'(wr_addr), FW - 1);

    // Randomised frames
    for (int f = 0; f < 6; f++) begin
      int nl;
      nl = $urandom_range(3, 5);
      for (int l = 0; l < nl; l++) lens[l] = ($urandom_range(0, 2) == 0) ? $urandom_range(5, 10) : 8;
      run_frame(nl, 1'b0);
      check_frame("random");
    end

    // Select dropped while waiting for frame start
    clear_obs();
    select = 1'b1;
    internal_vsync = 1'b1;
    tick(3);
    chk("wait.busy", 32'(busy), 1);
    select = 1'b0;
    tick(3);
    chk("wait.idle", 32'(busy), 0);
    chk("wait.noabort", abort_cnt, 0);

    // Abort after 6 words, then a mid-frame re-select must not capture
    clear_obs();
    frame_open();
    send_line(8, 1'b0, 1'b1);
    send_line(4, 1'b0, 1'b1);
    select = 1'b0;
    tick(3);
    chk("abort.pulse", abort_cnt, 1);
    chk("abort.nodone", done_cnt, 0);
    chk("abort.wc", 32'(word_count), 6);
    check_writes("abort");
    select = 1'b1;
    send_line(8, 1'b0, 1'b0);
    send_line(8, 1'b0, 1'b0);
    chk("join.nowr", got_q.size(), 6);
    chk("join.idle", 32'(busy), 0);
    for (int l = 0; l < 4; l++) lens[l] = 8;
    run_frame(4, 1'b0);
    check_frame("join");

    // Reset during capture after 3 words
    clear_obs();
    frame_open();
    href = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pixel_valid = 1'b1;
      pixel_byte = 8'($urandom_range(0, 255));
      tick(1);
      pixel_valid = 1'b0;
      tick(1);
    end
    reset = 1'b1;
    tick(1);
    chk("rst.outs", {wr_en, wr_addr, wr_data, busy, frame_done, frame_err, abort, word_count}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pixel_valid = 1'b1;
      tick(1);
      pixel_valid = 1'b0;
      tick(1);
    end
    href = 1'b0;
    tick(3);
    chk("rst.nwr", got_q.size(), 3);
    chk("rst.nodone", done_cnt, 0);
    chk("rst.noabort", abort_cnt, 0);
    chk("rst.idle", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
